// File: rtl/note_pkg.sv
// Shared definitions for the note player: pitch table, special codes,
// controller states and the elaboration-time half-period helper.
package note_pkg;

    localparam int unsigned NOTE_REST  = 0;
    localparam int unsigned REF_OCTAVE = 4;

    // Reference-octave pitches C4..B4 in centi-hertz, indexed by note code.
    localparam int unsigned FREQ_CHZ [1:7] = '{26163, 29366, 32963, 34923,
                                               39200, 44000, 49388};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Half-period in clock cycles of a reference-octave note:
    // clk / (2 * f) with f in centi-hertz gives clk * 50 / f_cHz.
    // Wide arithmetic so a 100 MHz clock times 50 does not overflow.
    function automatic logic [31:0] base_hp(input longint unsigned clk_hz,
                                            input int unsigned n);
        longint unsigned q;
        q = (clk_hz * 64'd50) / 64'(FREQ_CHZ[n]);
        return q[31:0];
    endfunction

endpackage

// File: rtl/square_osc.sv
// Free-running square-wave phase generator. Counts half-periods while run
// is high; holds everything at zero while run is low so every note starts
// from a clean phase.
module square_osc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] hp,
    output logic        phase,
    output logic        wrap
);

    logic [31:0] hp_cnt;

    // wrap marks the cycle whose closing edge flips the phase
    assign wrap = run && (hp_cnt == hp - 32'd1);

    // half-period counter and phase flip-flop
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            hp_cnt <= '0;
            phase  <= 1'b0;
        end else if (wrap) begin
            hp_cnt <= '0;
            phase  <= ~phase;
        end else begin
            hp_cnt <= hp_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/note_player.sv
// Square-wave note player: accepts one note/rest command at a time, plays it
// for a duration derived from full_ms and length, optionally follows it with
// a silent gap, and signals completion with a one-cycle done pulse.
module note_player
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned OCTAVE_BITS  = 3,
    parameter int unsigned NOTE_BITS    = 3,
    parameter int unsigned LENGTH_BITS  = 3,
    parameter int unsigned FULL_MS_BITS = 12,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OCTAVE_BITS-1:0]  octave,
    input  logic [NOTE_BITS-1:0]    note,
    input  logic [LENGTH_BITS-1:0]  length,
    input  logic [FULL_MS_BITS-1:0] full_ms,
    input  logic                    abort,
    output logic                    buzzer,
    output logic                    busy,
    output logic                    done
);

    localparam logic [39:0] CYC_PER_MS = 40'(CLK_HZ / 1000);
    localparam logic [OCTAVE_BITS-1:0] REF_OCT = OCTAVE_BITS'(REF_OCTAVE);
    localparam logic [39:0] GAP_LAST = (GAP_CYCLES == 0) ? 40'd0 : 40'(GAP_CYCLES - 1);

    // Entry 0 (rest) is never heard; it clamps to the minimum half-period.
    localparam logic [31:0] BASE [8] = '{32'd0,
                                         base_hp(64'(CLK_HZ), 1), base_hp(64'(CLK_HZ), 2),
                                         base_hp(64'(CLK_HZ), 3), base_hp(64'(CLK_HZ), 4),
                                         base_hp(64'(CLK_HZ), 5), base_hp(64'(CLK_HZ), 6),
                                         base_hp(64'(CLK_HZ), 7)};

    // A half-period below 2 cycles cannot form a square wave.
    function automatic logic [31:0] clamp_hp(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction

    // Very short notes still occupy at least one cycle.
    function automatic logic [39:0] floor_dur(input logic [39:0] v);
        return (v == 40'd0) ? 40'd1 : v;
    endfunction

    state_t      state, state_nxt;
    logic [31:0] hp_raw, hp_q;
    logic [39:0] dur_raw, dur_q, cnt;
    logic        tone_q, accept, tone_end, gap_end, phase, wrap;

    assign accept   = in_valid && in_ready;
    assign tone_end = (cnt == dur_q - 40'd1);
    assign gap_end  = (cnt == GAP_LAST);
    assign busy     = !in_ready;

    // pitch and duration of the command currently presented
    always_comb begin
        hp_raw = BASE[3'(note)];
        if (octave < REF_OCT) begin
            hp_raw = hp_raw << (REF_OCT - octave);
        end else if (octave > REF_OCT) begin
            hp_raw = hp_raw >> (octave - REF_OCT);
        end
        dur_raw = (40'(full_ms) * CYC_PER_MS) >> length;
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and handshake decode; abort only matters while busy
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = TONE;
            end
            TONE: begin
                if (abort) state_nxt = IDLE;
                else if (tone_end) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (abort || gap_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // command latch; held until the next accepted command
    always_ff @(posedge clk) begin
        if (accept) begin
            hp_q   <= clamp_hp(hp_raw);
            dur_q  <= floor_dur(dur_raw);
            tone_q <= (note != '0);
        end
    end

    // duration/gap counter, registered buzzer and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            buzzer <= 1'b0;
            done   <= 1'b0;
        end else begin
            buzzer <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) cnt <= '0;
                end
                TONE: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (tone_end) begin
                        cnt  <= '0;
                        done <= (GAP_CYCLES == 0);
                    end else begin
                        cnt    <= cnt + 40'd1;
                        // next phase value, so the edge that flips the
                        // oscillator is also the edge the pin changes on
                        buzzer <= tone_q && (phase ^ wrap);
                    end
                end
                GAP: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (gap_end) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + 40'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    square_osc u_osc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == TONE),
        .hp    (hp_q),
        .phase (phase),
        .wrap  (wrap)
    );

endmodule
